// File: rtl/alu_arb_pkg.sv
// Shared types and helpers for the round-robin ALU arbiter (alu_arbiter).
package alu_arb_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } arb_state_t;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_OP_W   = 4;

  // Pointer value after a grant to requester g among n requesters.
  function automatic int rr_next(input int g, input int n);
    return (g + 1) % n;
  endfunction

endpackage

// File: rtl/alu_rr_arbiter.sv
// Round-robin pointer plus combinational one-hot grant: the scan starts at the
// pointer and the first valid requester wins.
module alu_rr_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int PTR_W = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               allow,
  input  logic [NUM_REQ-1:0] valid,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   grant_idx
);

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] idx;
  logic             found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = PTR_W'((int'(ptr) + k) % NUM_REQ);
      if (allow && !found && valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= PTR_W'(rr_next(int'(grant_idx), NUM_REQ));
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one pipelined ALU between NUM_REQ requesters and routes each result back
// to its owner. Define ALU_ARB_STATS_EN to add per-requester saturating grant counters.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int OP_W    = DEF_OP_W,
  parameter int ALU_LAT = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*OP_W-1:0]   req_op,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic                      alu_valid,
  output logic [OP_W-1:0]           alu_op,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  input  logic [DATA_W-1:0]         alu_result,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      busy,
  output logic                      halted
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]     grant_cnt
`endif
);

  localparam int PTR_W = $clog2(NUM_REQ);

  arb_state_t                        state, state_nxt;
  logic [NUM_REQ-1:0]                grant;
  logic [PTR_W-1:0]                  gidx;
  logic                              xfer;
  logic                              allow;
  logic [NUM_REQ-1:0]                owner_q;
  logic [ALU_LAT-1:0]                trk_v;
  logic [ALU_LAT-1:0][NUM_REQ-1:0]   trk_own;

  // Handshake: requester i transfers when req_valid[i] & req_ready[i]; it holds
  // valid and payload until then. A falling en blocks grants in that same cycle.
  assign allow = (state == RUN) && en && !rst;

  alu_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk       (clk),
    .rst       (rst),
    .allow     (allow),
    .valid     (req_valid),
    .grant     (grant),
    .grant_idx (gidx)
  );

  assign req_ready = grant;
  assign xfer      = |grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_valid <= 1'b0;
      alu_op    <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      owner_q   <= '0;
    end else begin
      alu_valid <= xfer;
      owner_q   <= grant;
      if (xfer) begin
        alu_op <= req_op[int'(gidx)*OP_W +: OP_W];
        alu_a  <= req_a[int'(gidx)*DATA_W +: DATA_W];
        alu_b  <= req_b[int'(gidx)*DATA_W +: DATA_W];
      end
    end
  end

  // Tracker entries follow alu_valid, so the tail lines up with alu_result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trk_v   <= '0;
      trk_own <= '0;
    end else begin
      trk_v[0]   <= alu_valid;
      trk_own[0] <= owner_q;
      for (int k = 1; k < ALU_LAT; k++) begin
        trk_v[k]   <= trk_v[k-1];
        trk_own[k] <= trk_own[k-1];
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    if (trk_v[ALU_LAT-1]) begin
      rsp_valid = trk_own[ALU_LAT-1];
      rsp_data  = alu_result;
    end
  end

  assign busy   = (|trk_v) | alu_valid;
  assign halted = (state == HALT);

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (!en) state_nxt = DRAIN;
      DRAIN:   if (en) state_nxt = RUN;
               else if (!busy) state_nxt = HALT;
      HALT:    if (en) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

`ifdef ALU_ARB_STATS_EN
  logic [NUM_REQ-1:0][15:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i] && cnt[i] != 16'hFFFF) cnt[i] <= cnt[i] + 16'd1;
      end
    end
  end

  assign grant_cnt = cnt;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized scoreboard bench for alu_arbiter; with ALU_ARB_STATS_EN defined it
// also exercises grant counter saturation.
module tb_alu_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
  localparam int OP_W    = 4;
  localparam int ALU_LAT = 2;
  localparam int ISS_W   = 32 + OP_W + 2*DATA_W;
  localparam int EXP_W   = 32 + NUM_REQ + DATA_W;

  logic                      clk;
  logic                      rst;
  logic                      en;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*OP_W-1:0]   req_op;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic                      alu_valid;
  logic [OP_W-1:0]           alu_op;
  logic [DATA_W-1:0]         alu_a;
  logic [DATA_W-1:0]         alu_b;
  logic [DATA_W-1:0]         alu_result;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic                      busy;
  logic                      halted;
`ifdef ALU_ARB_STATS_EN
  logic [NUM_REQ*16-1:0]     grant_cnt;
`endif

  alu_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .OP_W(OP_W), .ALU_LAT(ALU_LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .alu_valid  (alu_valid),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .busy       (busy),
    .halted     (halted)
`ifdef ALU_ARB_STATS_EN
    ,
    .grant_cnt  (grant_cnt)
`endif
  );

  // ---------------- clock / cycle counter ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- ALU model: fixed latency pipe ----------------
  function automatic logic [DATA_W-1:0] alu_fn(input logic [OP_W-1:0] op,
                                               input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    case (op[1:0])
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a ^ b;
    endcase
  endfunction

  logic [DATA_W-1:0] pipe [ALU_LAT];
  always @(posedge clk) begin
    pipe[0] <= alu_valid ? alu_fn(alu_op, alu_a, alu_b) : '0;
    for (int k = 1; k < ALU_LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign alu_result = pipe[ALU_LAT-1];

  // ---------------- scoreboard state ----------------
  logic [ISS_W-1:0] iss_q[$];
  logic [EXP_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  logic              pend [NUM_REQ];
  logic [OP_W-1:0]   p_op [NUM_REQ];
  logic [DATA_W-1:0] p_a  [NUM_REQ];
  logic [DATA_W-1:0] p_b  [NUM_REQ];
  int                m_cnt[NUM_REQ];
  int                m_ptr;
  int                m_state;   // 0 run, 1 drain, 2 halt
  int                last_busy;
  logic [OP_W-1:0]   last_op;
  logic [DATA_W-1:0] last_a, last_b;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    iss_q.delete();
    m_ptr     = 0;
    m_state   = 0;
    last_busy = -100;
    last_op   = '0;
    last_a    = '0;
    last_b    = '0;
    for (int i = 0; i < NUM_REQ; i++) m_cnt[i] = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_req(input int i, input logic [OP_W-1:0] op,
                         input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    pend[i] = 1'b1;
    p_op[i] = op;
    p_a[i]  = a;
    p_b[i]  = b;
  endtask

  task automatic drive();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i]                = pend[i];
      req_op[i*OP_W +: OP_W]      = p_op[i];
      req_a[i*DATA_W +: DATA_W]   = p_a[i];
      req_b[i*DATA_W +: DATA_W]   = p_b[i];
    end
  endtask

  // One cycle of stimulus plus the reference model's view of that cycle.
  task automatic eval(input logic en_v, input logic [NUM_REQ-1:0] newreq);
    int g;
    int idx;
    logic [NUM_REQ-1:0] exp_rdy;
    bit busy_c;
    en = en_v;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (newreq[i] && !pend[i])
        set_req(i, OP_W'($urandom_range(0, (1 << OP_W) - 1)),
                DATA_W'($urandom_range(0, 255)), DATA_W'($urandom_range(0, 255)));
    end
    drive();
    #1;
    busy_c  = (cyc <= last_busy);
    g       = -1;
    exp_rdy = '0;
    if (m_state == 0 && en_v) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = (m_ptr + k) % NUM_REQ;
        if (g < 0 && pend[idx]) g = idx;
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", req_ready, exp_rdy);
    chk("busy", busy, busy_c);
    chk("halted", halted, m_state == 2);
    if (g >= 0) begin
      iss_q.push_back({32'(cyc + 1), p_op[g], p_a[g], p_b[g]});
      exp_q.push_back({32'(cyc + 1 + ALU_LAT), exp_rdy, alu_fn(p_op[g], p_a[g], p_b[g])});
      last_busy = cyc + 1 + ALU_LAT;
      m_ptr     = (g + 1) % NUM_REQ;
      pend[g]   = 1'b0;
      if (m_cnt[g] < 65535) m_cnt[g]++;
    end
    case (m_state)
      0:       if (!en_v) m_state = 1;
      1:       if (en_v) m_state = 0; else if (!busy_c) m_state = 2;
      default: if (en_v) m_state = 0;
    endcase
  endtask

  task automatic cycle(input logic en_v, input logic [NUM_REQ-1:0] newreq);
    @(negedge clk);
    eval(en_v, newreq);
  endtask

  task automatic assert_rst();
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_req_ready", req_ready, '0);
    chk("rst_issue", {alu_valid, alu_op, alu_a, alu_b}, '0);
    chk("rst_rsp", {rsp_valid, rsp_data}, '0);
    chk("rst_status", {busy, halted}, '0);
`ifdef ALU_ARB_STATS_EN
    chk("rst_grant_cnt", grant_cnt, '0);
`endif
  endtask

  task automatic release_rst(input logic [NUM_REQ-1:0] newreq);
    @(negedge clk);
    rst = 1'b0;
    eval(1'b1, newreq);
  endtask

  // ---------------- monitor ----------------
  logic [ISS_W-1:0] mon_iss;
  logic [EXP_W-1:0] mon_exp;
  bit iss_due, rsp_due;

  always @(negedge clk) begin
    if (!rst) begin
      iss_due = (iss_q.size() > 0) && ($signed(iss_q[0][ISS_W-1 -: 32]) <= cyc);
      chk("alu_valid", alu_valid, iss_due);
      if (iss_due) begin
        mon_iss = iss_q.pop_front();
        last_op = mon_iss[2*DATA_W +: OP_W];
        last_a  = mon_iss[DATA_W +: DATA_W];
        last_b  = mon_iss[0 +: DATA_W];
      end
      chk("alu_payload", {alu_op, alu_a, alu_b}, {last_op, last_a, last_b});
      rsp_due = (exp_q.size() > 0) && ($signed(exp_q[0][EXP_W-1 -: 32]) <= cyc);
      mon_exp = '0;
      if (rsp_due) mon_exp = exp_q.pop_front();
      chk("rsp_valid", rsp_valid, mon_exp[DATA_W +: NUM_REQ]);
      chk("rsp_data", rsp_data, mon_exp[0 +: DATA_W]);
    end
  end

  // ---------------- stimulus ----------------
  int off;

  initial begin
    rst = 1'b0;
    en = 1'b0;
    req_valid = '0;
    req_op = '0;
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pend[i] = 1'b0;
      p_op[i] = '0;
      p_a[i]  = '0;
      p_b[i]  = '0;
    end
    #2;
    assert_rst();
    repeat (2) @(negedge clk);
    release_rst('0);

    // single ADD request from requester 2
    set_req(2, 4'd0, 8'h05, 8'h03);
    repeat (6) cycle(1'b1, '0);

    // round robin from reset with all four requesting
    #2;
    assert_rst();
    release_rst('1);
    repeat (7) cycle(1'b1, '1);
    repeat (3) cycle(1'b1, '0);

    // pointer skip with valid = 1001 and pointer = 1
    cycle(1'b1, 4'b0001);
    repeat (3) cycle(1'b1, 4'b1001);

    // drain and halt with two ops in flight
    cycle(1'b1, 4'b0010);
    cycle(1'b1, '0);
    repeat (8) cycle(1'b0, 4'b1100);
    repeat (4) cycle(1'b1, '0);

    // reset one cycle after an issue
    set_req(1, 4'd1, 8'h40, 8'h11);
    cycle(1'b1, '0);
    cycle(1'b1, '0);
    #1;
    for (int i = 0; i < NUM_REQ; i++)
      if (!pend[i]) set_req(i, OP_W'(i), DATA_W'(8'h10 + i), DATA_W'(8'h20 + i));
    drive();
    assert_rst();
    release_rst('0);
    repeat (ALU_LAT + 3) cycle(1'b1, '0);

    // randomized traffic with occasional en drops
    off = 0;
    repeat (2000) begin
      if (off > 0) off--;
      else if ($urandom_range(0, 39) == 0) off = $urandom_range(1, 12);
      cycle(off == 0, NUM_REQ'($urandom) & NUM_REQ'($urandom | $urandom));
    end

`ifdef ALU_ARB_STATS_EN
    #2;
    assert_rst();
    release_rst(4'b0010);
    repeat (70000) cycle(1'b1, 4'b0010);
    repeat (ALU_LAT + 3) cycle(1'b1, '0);
    for (int i = 0; i < NUM_REQ; i++)
      chk("grant_cnt", grant_cnt[i*16 +: 16], 64'(m_cnt[i]));
`endif

    repeat (NUM_REQ + 2) cycle(1'b1, '0);
    repeat (ALU_LAT + 3) cycle(1'b1, '0);
    chk("iss_q_empty", 64'(iss_q.size()), 64'd0);
    chk("exp_q_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one pipelined ALU between NUM_REQ requesters using round-robin arbitration.
- Issues at most one operation per cycle to the ALU.
- Tracks the owner of each in-flight operation and routes the result back to that requester ALU_LAT cycles later.
- A run/drain/halt FSM lets the environment quiesce the ALU cleanly before reconfiguration or checking.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, operand and result width.
- OP_W, 4, opcode width.
- ALU_LAT, 2, fixed ALU latency in cycles from alu_valid to alu_result (1..8).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  1 = arbitrate and issue; 0 = drain, then halt.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester grant; one-hot or zero.
- req_op  in  NUM_REQ*OP_W  flattened opcodes; requester i occupies [i*OP_W +: OP_W].
- req_a  in  NUM_REQ*DATA_W  flattened operand A.
- req_b  in  NUM_REQ*DATA_W  flattened operand B.
- alu_valid  out  1  issue strobe to the ALU.
- alu_op  out  OP_W  issued opcode.
- alu_a  out  DATA_W  issued operand A.
- alu_b  out  DATA_W  issued operand B.
- alu_result  in  DATA_W  ALU output, valid ALU_LAT cycles after the matching alu_valid.
- rsp_valid  out  NUM_REQ  one-cycle pulse to the owning requester.
- rsp_data  out  DATA_W  result, broadcast to all requesters; qualified by rsp_valid.
- busy  out  1  one or more operations in flight.
- halted  out  1  FSM is in HALT.

Behaviour:
- Reset (async, rst=1):
  - All outputs are 0.
  - Round-robin pointer = 0.
  - In-flight tracking is cleared.
  - FSM = RUN.
  - Asserting rst mid-operation discards in-flight operations; no rsp_valid is produced for them.
- Handshake:
  - A transfer occurs when req_valid[i] & req_ready[i] in the same cycle.
  - A requester holds valid and payload stable until granted; the arbiter never retracts a grant within a cycle.
- req_ready:
  - Combinational from req_valid, pointer and state.
  - Only in RUN, and at most one bit set.
- Arbitration:
  - Scan from pointer upward, modulo NUM_REQ; the first valid requester wins.
  - On a grant to requester g, pointer <= (g+1) mod NUM_REQ.
  - With no grant, the pointer holds.
- Issue path:
  - Registered; alu_valid, alu_op, alu_a and alu_b update on the clock edge after the transfer.
  - alu_op, alu_a and alu_b hold their last value when alu_valid=0.
- In-flight tracking:
  - Shift register of depth ALU_LAT carrying {valid, one-hot owner}.
  - Loaded in parallel with alu_valid.
- Response:
  - In the cycle where the tracker tail is valid: rsp_valid = tail owner one-hot and rsp_data = alu_result, both combinational.
  - Otherwise rsp_valid = 0 and rsp_data = 0.
  - Requesters cannot back-pressure responses.
- Throughput: one issue per cycle; back-to-back grants are allowed, including to the same requester when it is the only one valid.
- busy = any valid bit in the tracker, or alu_valid.
- FSM:
  - RUN: grants allowed. en=0 -> DRAIN.
  - DRAIN: no grants. en=1 -> RUN. Else when busy=0 -> HALT.
  - HALT: halted=1, no grants. en=1 -> RUN on the next cycle; grants resume in that RUN cycle.
- en falling in the same cycle as a request: no grant that cycle, since req_ready is gated by the current state, and the FSM moves to DRAIN.

Optional Feature:
- Macro: ALU_ARB_STATS_EN.
- Defined:
  - Adds output grant_cnt (NUM_REQ*16), one saturating 16-bit counter per requester.
  - Each counter increments on every transfer; it holds at 16'hFFFF.
  - Counters clear on rst.
- Undefined:
  - No port, no counters.
  - Behaviour is otherwise identical.

Decomposition:
- Package alu_arb_pkg holds:
  - enum arb_state_t {RUN, DRAIN, HALT}
  - localparam defaults for DATA_W/OP_W
  - a function for round-robin next-pointer computation
- Sub-module alu_rr_arbiter (NUM_REQ) holds the pointer register and combinational one-hot grant.
- alu_arbiter instantiates it and adds the issue registers, tracker, FSM and stats.

Test Plan:
- Single request: en=1, only req_valid[2], op=ADD, a=8'h05, b=8'h03.
  - req_ready[2] is high in cycle 0.
  - alu_valid is high in cycle 1 with a=05, b=03.
  - With ALU_LAT=2: rsp_valid=4'b0100 and rsp_data=8'h08 in cycle 3.
- Round-robin fairness: all four valid for 8 cycles from reset.
  - Grant order is 0,1,2,3,0,1,2,3.
  - Each response returns to the matching requester, in order.
- Pointer skip: valid = 4'b1001 with pointer=1.
  - Grant goes to 3, then to 0, then to 3.
- Drain and halt: en dropped while 2 ops are in flight.
  - No new req_ready.
  - Both responses are delivered.
  - halted rises one cycle after busy falls.
  - en=1 then restores grants the next cycle.
- Reset mid-flight: assert rst one cycle after an issue.
  - All outputs are 0 immediately.
  - No rsp_valid appears after reset release.
  - The first grant after release goes to requester 0.
- Stats (ALU_ARB_STATS_EN): 70000 grants to requester 1.
  - grant_cnt[1] saturates at 16'hFFFF.
  - All other counters are 0.
